// File: rtl/csr_io_if.sv
// CSR access bus between the writeback stage and the CSR/IO responder.
// The pipeline side drives the access and retire event; the responder
// returns the old CSR value and the illegal-address pulse.
interface csr_io_if #(
    parameter int WIDTH = 32
);
    logic             csr_en;
    logic [11:0]      csr_addr;
    logic [WIDTH-1:0] csr_wdata;
    logic             retire;
    logic [WIDTH-1:0] csr_rdata;
    logic             csr_illegal;

    modport master (
        output csr_en,
        output csr_addr,
        output csr_wdata,
        output retire,
        input  csr_rdata,
        input  csr_illegal
    );

    modport slave (
        input  csr_en,
        input  csr_addr,
        input  csr_wdata,
        input  retire,
        output csr_rdata,
        output csr_illegal
    );
endinterface

// File: rtl/csr_io_unit.sv
// CSR responder: memory-mapped GPIO plus 64-bit cycle/instret counters.
// Every access is a CSRRW: read data is the value before the access writes.
// Reading a low counter word snapshots its high word into a shadow so that
// a following read of the "h" CSR yields a tear-free 64-bit value.
module csr_io_unit #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] GPIO_in,
    csr_io_if.slave          bus,
    output logic [WIDTH-1:0] GPIO_out,
    output logic             gpio_out_strobe
);

    localparam logic [11:0] ADDR_IO0_IN    = 12'hF00;
    localparam logic [11:0] ADDR_IO2_OUT   = 12'hF02;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [63:0]      cycle_cnt;
    logic [63:0]      instret_cnt;
    logic [31:0]      cycle_shadow;
    logic [31:0]      instret_shadow;

    logic [WIDTH-1:0] rd_next;
    logic             illegal_next;
    logic             wr_gpio;
    logic             snap_cycle;
    logic             snap_instret;

    // Input synchronizer chain for the asynchronous board switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= GPIO_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Address decode: old value to return and which side effects the access has.
    always_comb begin
        rd_next      = '0;
        illegal_next = 1'b0;
        wr_gpio      = 1'b0;
        snap_cycle   = 1'b0;
        snap_instret = 1'b0;
        case (bus.csr_addr)
            ADDR_IO0_IN:   rd_next = sync_q[SYNC_STAGES-1];
            ADDR_IO2_OUT: begin
                rd_next = GPIO_out;
                wr_gpio = 1'b1;
            end
            ADDR_CYCLE: begin
                rd_next    = WIDTH'(cycle_cnt[31:0]);
                snap_cycle = 1'b1;
            end
            ADDR_CYCLEH:   rd_next = WIDTH'(cycle_shadow);
            ADDR_INSTRET: begin
                rd_next      = WIDTH'(instret_cnt[31:0]);
                snap_instret = 1'b1;
            end
            ADDR_INSTRETH: rd_next = WIDTH'(instret_shadow);
            default:       illegal_next = 1'b1;
        endcase
    end

    // Counters, shadows, output register and registered access response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt       <= '0;
            instret_cnt     <= '0;
            cycle_shadow    <= '0;
            instret_shadow  <= '0;
            GPIO_out        <= '0;
            gpio_out_strobe <= 1'b0;
            bus.csr_rdata   <= '0;
            bus.csr_illegal <= 1'b0;
        end else begin
            cycle_cnt       <= cycle_cnt + 64'd1;
            gpio_out_strobe <= bus.csr_en & wr_gpio;
            bus.csr_illegal <= bus.csr_en & illegal_next;
            if (bus.retire) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
            if (bus.csr_en) begin
                bus.csr_rdata <= rd_next;
                if (wr_gpio) begin
                    GPIO_out <= bus.csr_wdata;
                end
                if (snap_cycle) begin
                    cycle_shadow <= cycle_cnt[63:32];
                end
                if (snap_instret) begin
                    instret_shadow <= instret_cnt[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_io_unit.sv
// Scoreboard bench for csr_io_unit: each access pushes its expected response,
// which is popped and compared one edge later.
module tb_csr_io_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] GPIO_in = '0;
    logic [31:0] GPIO_out;
    logic        gpio_out_strobe;

    csr_io_if #(.WIDTH(32)) bus ();

    csr_io_unit #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .GPIO_in         (GPIO_in),
        .bus             (bus),
        .GPIO_out        (GPIO_out),
        .gpio_out_strobe (gpio_out_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        illegal;
        logic        strobe;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one access at the falling edge; compare after the sampling edge.
    task automatic access(input string tag, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_ill, input logic exp_stb);
        exp_t e;
        @(negedge clk);
        bus.csr_en    = 1'b1;
        bus.csr_addr  = addr;
        bus.csr_wdata = wdata;
        sb.push_back('{tag, exp_rd, exp_ill, exp_stb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".rdata"},   64'(bus.csr_rdata),   64'(e.rdata));
        chk({e.tag, ".illegal"}, 64'(bus.csr_illegal), 64'(e.illegal));
        chk({e.tag, ".strobe"},  64'(gpio_out_strobe), 64'(e.strobe));
    endtask

    // One idle edge: response must hold, pulses must drop.
    task automatic idle(input string tag, input logic [31:0] hold_rd);
        @(negedge clk);
        bus.csr_en = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".hold"},    64'(bus.csr_rdata),   64'(hold_rd));
        chk({tag, ".ill0"},    64'(bus.csr_illegal), 64'd0);
        chk({tag, ".stb0"},    64'(gpio_out_strobe), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.csr_en    = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_wdata = '0;
        bus.retire    = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rdata",  64'(bus.csr_rdata),   64'd0);
        chk("rst.gpio",   64'(GPIO_out),        64'd0);
        chk("rst.ill",    64'(bus.csr_illegal), 64'd0);
        chk("rst.strobe", 64'(gpio_out_strobe), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        access("cycle10", 12'hC00, 32'hFFFF_FFFF, 32'h0000_000A, 1'b0, 1'b0);
        access("cycleh0", 12'hC80, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("idle.gpio", 64'(GPIO_out), 64'd0);

        // Instret collision: retire on 5 edges, read on the 5th
        @(negedge clk);
        bus.csr_en = 1'b0;
        bus.retire = 1'b1;
        repeat (4) @(posedge clk);
        access("instret_col", 12'hC02, 32'h0, 32'd4, 1'b0, 1'b0);
        bus.retire = 1'b0;
        access("instret5", 12'hC02, 32'h0, 32'd5, 1'b0, 1'b0);
        access("instreth", 12'hC82, 32'h0, 32'd0, 1'b0, 1'b0);

        // io2_out write/read
        access("wr_dead", 12'hF02, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        chk("gpio_dead", 64'(GPIO_out), 64'hDEAD_BEEF);
        idle("after_wr", 32'h0);
        access("wr_1234", 12'hF02, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b1);
        access("wr_back", 12'hF02, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        chk("gpio_1234", 64'(GPIO_out), 64'h1234_5678);

        // Input synchronizer latency
        @(negedge clk);
        bus.csr_en = 1'b0;
        GPIO_in = 32'h0000_00A5;
        @(posedge clk);
        access("sync_old", 12'hF00, 32'h0, 32'h0, 1'b0, 1'b0);
        access("sync_new", 12'hF00, 32'h0, 32'hA5, 1'b0, 1'b0);
        access("ro_write", 12'hF00, 32'hFFFF_FFFF, 32'hA5, 1'b0, 1'b0);
        access("ro_after", 12'hF00, 32'h0, 32'hA5, 1'b0, 1'b0);
        chk("ro_gpio", 64'(GPIO_out), 64'h1234_5678);

        // Illegal address
        access("illegal", 12'h300, 32'h55, 32'h0, 1'b1, 1'b0);
        chk("ill_gpio", 64'(GPIO_out), 64'h1234_5678);
        idle("after_ill", 32'h0);

        // Cycle snapshot across a carry into the high word
        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFF;
        release dut.cycle_cnt;
        bus.csr_en   = 1'b1;
        bus.csr_addr = 12'hC00;
        sb.push_back('{"snap_lo", 32'hFFFF_FFFF, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".rdata"}, 64'(bus.csr_rdata), 64'(e.rdata));
        end
        access("snap_hi",  12'hC80, 32'h0, 32'h1, 1'b0, 1'b0);
        access("live_lo",  12'hC00, 32'h0, 32'h1, 1'b0, 1'b0);
        access("live_hi",  12'hC80, 32'h0, 32'h2, 1'b0, 1'b0);

        // 64-bit wrap to zero
        @(negedge clk);
        bus.csr_en = 1'b0;
        force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut.cycle_cnt;
        @(posedge clk);
        access("wrap_lo", 12'hC00, 32'h0, 32'h0, 1'b0, 1'b0);
        access("wrap_hi", 12'hC80, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset asserted mid-access drops the write
        @(negedge clk);
        bus.csr_en    = 1'b1;
        bus.csr_addr  = 12'hF02;
        bus.csr_wdata = 32'hCAFE_F00D;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.gpio",   64'(GPIO_out),        64'd0);
        chk("midrst.strobe", 64'(gpio_out_strobe), 64'd0);
        chk("midrst.rdata",  64'(bus.csr_rdata),   64'd0);
        @(negedge clk);
        bus.csr_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst.gpio",   64'(GPIO_out),        64'd0);
        chk("postrst.strobe", 64'(gpio_out_strobe), 64'd0);
        access("first_edge", 12'hC00, 32'h0, 32'h1, 1'b0, 1'b0);
        access("instret_rst", 12'hC02, 32'h0, 32'h0, 1'b0, 1'b0);
        idle("final", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_io_unit.md
# csr_io_unit

CSR responder for the RISC-V core. It services every CSRRW the pipeline issues and implements the memory-mapped I/O and counter CSRs. It samples the board input port, drives the board output port, and keeps 64-bit cycle and retired-instruction counters. It sits beside the writeback stage, and its read data feeds the writeback mux as the old CSR value for rd.

## Interface
- `WIDTH`, default 32: CSR data width and GPIO width.
- `SYNC_STAGES`, default 2: flop depth of the `GPIO_in` synchronizer. Legal values are ≥2.
- `clk` input, 1 bit: the only clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `GPIO_in` input, WIDTH bits: asynchronous board switches.
- `csr_en` input, 1 bit: a valid CSRRW is in the stage this cycle.
- `csr_addr` input, 12 bits: CSR address, instruction bits [31:20].
- `csr_wdata` input, WIDTH bits: the rs1 value to write.
- `retire` input, 1 bit: one instruction retired this cycle.
- `csr_rdata` output, WIDTH bits: old CSR value, registered.
- `csr_illegal` output, 1 bit: one-cycle pulse for an unmapped address.
- `GPIO_out` output, WIDTH bits: board output register, shown on the hex display.
- `gpio_out_strobe` output, 1 bit: one-cycle pulse after each write to `GPIO_out`.

## Operation
CSR map:
- 0xF00 io0_in: read-only. Returns the last synchronizer stage. Writes are silently ignored and are not illegal.
- 0xF02 io2_out: read/write. Holds the `GPIO_out` register.
- 0xC00 cycle: read-only, low 32 bits of `cycle_cnt`. The same read also copies the high 32 bits into `cycle_shadow`.
- 0xC80 cycleh: read-only. Returns `cycle_shadow`, not the live high word. Software therefore reads C00 then C80 for a tear-free 64-bit value.
- 0xC02 instret: read-only, low 32 bits of `instret_cnt`. The same read also copies the high 32 bits into `instret_shadow`.
- 0xC82 instreth: read-only. Returns `instret_shadow`.
- Any other address: `csr_rdata` is 0, `csr_illegal` pulses, and no state changes.

Access rules:
- CSRRW semantics: read data is always the value before any write made by the same access.
- For read-only CSRs, `csr_wdata` is ignored.

Counters:
- `cycle_cnt` is 64 bits. It increments on every edge while `rst` is low and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- `instret_cnt` is 64 bits. It increments on each edge where `retire`=1, with the same wrap.

Idle behaviour:
- When `csr_en`=0, `csr_rdata` holds its last value.
- When `csr_en`=0, `csr_illegal` and `gpio_out_strobe` are 0.

## Timing
Reset:
- While `rst` is high, all of the following are 0 and stay 0: `csr_rdata`, `csr_illegal`, `GPIO_out`, `gpio_out_strobe`, both counters, both shadows, and every synchronizer flop.
- The first rising edge with `rst` low makes `cycle_cnt`=1.
- Reset asserted mid-access drops the access: no write takes effect and no strobe is issued.

Access latency (access sampled at edge N):
- `csr_rdata` and `csr_illegal` are valid in cycle N (after edge N) until edge N+1.
- `csr_rdata` then holds until the next access.
- A write to io2_out is visible on `GPIO_out` after edge N.
- `gpio_out_strobe` is high from edge N to edge N+1.
- Back-to-back accesses are allowed every cycle, with no stall or handshake.

Counter reads:
- A read of cycle or instret at edge N returns the pre-increment value, i.e. the value held just before edge N.
- The shadow is updated at the same edge N.
- `retire`=1 on the same edge as an instret read: the read returns the old count, and the counter still increments.

Input synchronizer:
- `GPIO_in` stable before edge k appears in the last stage after edge k+SYNC_STAGES−1.
- A read sampled at edge k+SYNC_STAGES or later returns the new value; an earlier read returns the old one.

Widths:
- Counters are unsigned 64-bit. The wrap on overflow is silent, with no flag.

## Test plan
- Reset then idle: hold `rst`=1 for 3 cycles, release, run 10 edges, read 0xC00 → `csr_rdata`=0x0000000A. `GPIO_out`=0 throughout.
- Write/read io2_out:
  - Access at edge N: write 0xF02 with 0xDEADBEEF → `csr_rdata`=0, `GPIO_out`=0xDEADBEEF after edge N, `gpio_out_strobe` pulses exactly once.
  - Then write 0xF02 with 0x12345678 → `csr_rdata`=0xDEADBEEF.
- Input sync: set `GPIO_in`=0x0000_00A5 just before edge k.
  - Read 0xF00 at edge k+1 → old value 0.
  - Read 0xF00 at edge k+2 → 0x000000A5.
  - A write of 0xFFFFFFFF to 0xF00 → no `csr_illegal`, and a later read still returns 0xA5.
- Cycle snapshot and wrap: force `cycle_cnt`=0x0000_0001_FFFF_FFFF.
  - Read 0xC00 → 0xFFFFFFFF, and the shadow captures 1.
  - Read 0xC80 on the next edge → 0x00000001, even though the live high word is now 2.
- Instret collision: drive `retire`=1 for 5 edges, reading 0xC02 on the 5th → returns 4, and the final count is 5.
- Illegal address: access 0x300 with `csr_wdata`=0x55 → `csr_rdata`=0, `csr_illegal` high for one cycle, `GPIO_out` unchanged.
- Mid-access reset: assert `rst` between `csr_en` going high and the next edge while writing 0xF02 → `GPIO_out` stays 0 and no strobe occurs.
